// File: rtl/gray_counter_pkg.sv
// Shared constants for the Gray-code up/down counter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package gray_counter_pkg;

  // Default counter width; the counter needs at least two bits to form a Gray sequence.
  localparam int GC_DEFAULT_WIDTH = 3;
  localparam int GC_MIN_WIDTH     = 2;

endpackage : gray_counter_pkg

// File: rtl/gray_counter_gray_to_bin.sv
// Gray-code to binary decoder: each binary bit is the XOR of all Gray bits at or above it.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input continuously.
module gray_to_bin
  import gray_counter_pkg::*;
#(
  parameter int WIDTH = GC_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  // Prefix XOR from the MSB down: shifting right by i leaves exactly the bits g[WIDTH-1:i].
  always_comb begin
    bin_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin_o[i] = ^(gray_i >> i);
    end
  end

endmodule : gray_to_bin

// File: rtl/gray_counter.sv
// Up/down counter with registered binary and Gray outputs, Gray parallel load and wrap pulse.
// Latency: one cycle from en/load to bin_q/gray_q/wrap; tc is combinational from state and up.
// Backpressure: none; every enabled cycle steps, load has priority over en, en over hold.
module gray_counter
  import gray_counter_pkg::*;
#(
  parameter int WIDTH = GC_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] bin_q,
  output logic [WIDTH-1:0] gray_q,
  output logic             wrap,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_BIN = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_d;
  logic             wrap_d;
  logic             wrap_q;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] step_bin;

  // Decode the incoming Gray load value so the binary register stays consistent with it.
  gray_to_bin #(
    .WIDTH (WIDTH)
  ) u_load_dec (
    .gray_i (load_gray),
    .bin_o  (load_bin)
  );

  // Terminal count looks at the current state in the currently requested direction.
  always_comb begin
    tc = up ? (bin_q == MAX_BIN) : (bin_q == '0);
  end

  // Next state: load beats step beats hold; Gray is re-encoded from the next binary value
  // so both outputs move on the same edge.
  always_comb begin
    bin_d    = bin_q;
    gray_d   = gray_q;
    wrap_d   = 1'b0;
    step_bin = up ? (bin_q + ONE) : (bin_q - ONE);
    if (load) begin
      bin_d  = load_bin;
      gray_d = load_gray;
    end else if (en) begin
      bin_d  = step_bin;
      gray_d = step_bin ^ (step_bin >> 1);
      wrap_d = tc;
    end
  end

  // State registers; reset clears everything immediately without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;

endmodule : gray_counter

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter at WIDTH=3 with hand-computed expectations.
// Latency: outputs sampled 1 time unit after the rising edge that produced them.
// Backpressure: not applicable.
module tb_gray_counter;

  localparam int W = 3;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] load_gray;
  logic [W-1:0] bin_q;
  logic [W-1:0] gray_q;
  logic         wrap;
  logic         tc;

  int checks;
  int errors;

  gray_counter #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .up        (up),
    .load      (load),
    .load_gray (load_gray),
    .bin_q     (bin_q),
    .gray_q    (gray_q),
    .wrap      (wrap),
    .tc        (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [W-1:0] eb, input logic [W-1:0] eg,
                           input logic ew);
    chk({tag, ".bin"},  {29'd0, bin_q},  {29'd0, eb});
    chk({tag, ".gray"}, {29'd0, gray_q}, {29'd0, eg});
    chk({tag, ".wrap"}, {31'd0, wrap},   {31'd0, ew});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] up_gray [8];

  initial begin
    checks = 0;
    errors = 0;
    up_gray[0] = 3'b001; up_gray[1] = 3'b011; up_gray[2] = 3'b010; up_gray[3] = 3'b110;
    up_gray[4] = 3'b111; up_gray[5] = 3'b101; up_gray[6] = 3'b100; up_gray[7] = 3'b000;

    rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_gray = '0;

    // Reset state and tc at zero in both directions.
    #3;
    chk_state("reset", 3'b000, 3'b000, 1'b0);
    chk("reset.tc_up", {31'd0, tc}, 32'd0);
    up = 1'b0;
    #1;
    chk("reset.tc_dn", {31'd0, tc}, 32'd1);
    up = 1'b1;
    #3;
    rst_n = 1'b1;

    // Eight up steps: full Gray cycle, tc only at 111, wrap only after the 8th edge.
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("up%0d.tc", k), {31'd0, tc}, (k == 7) ? 32'd1 : 32'd0);
      step();
      chk_state($sformatf("up%0d", k), 3'((k + 1) % 8), up_gray[k], (k == 7));
    end

    // Down from zero wraps to 111, then steps to 110 without wrap.
    up = 1'b0;
    #1;
    chk("dn0.tc", {31'd0, tc}, 32'd1);
    step();
    chk_state("dn0", 3'b111, 3'b100, 1'b1);
    step();
    chk_state("dn1", 3'b110, 3'b101, 1'b0);

    // Load Gray 110 -> binary 100, then one up step.
    en = 1'b0; load = 1'b1; load_gray = 3'b110;
    step();
    chk_state("load110", 3'b100, 3'b110, 1'b0);
    load = 1'b0; en = 1'b1; up = 1'b1;
    step();
    chk_state("load110.up", 3'b101, 3'b111, 1'b0);

    // Load and en on the same edge: load wins, no step applied.
    load = 1'b1; load_gray = 3'b011;
    step();
    chk_state("load_en", 3'b010, 3'b011, 1'b0);

    // Park at 111 and hold for five cycles while up toggles; tc follows up.
    en = 1'b0; load_gray = 3'b100;
    step();
    chk_state("load100", 3'b111, 3'b100, 1'b0);
    load = 1'b0;
    for (int k = 0; k < 5; k++) begin
      up = (k % 2 == 0) ? 1'b0 : 1'b1;
      #1;
      chk($sformatf("hold%0d.tc", k), {31'd0, tc}, (k % 2 == 0) ? 32'd0 : 32'd1);
      step();
      chk_state($sformatf("hold%0d", k), 3'b111, 3'b100, 1'b0);
    end

    // Consecutive wrapping steps with a direction change and no idle cycle.
    en = 1'b1; up = 1'b1;
    step();
    chk_state("wrap_up", 3'b000, 3'b000, 1'b1);
    up = 1'b0;
    step();
    chk_state("wrap_dn", 3'b111, 3'b100, 1'b1);

    // Asynchronous reset mid-count, no clock edge in between.
    en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("async_rst", 3'b000, 3'b000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_gray_counter
